// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM handshake bundle for mem_access_ctrl.
// master: the controller's view; slave: the datapath + ram_256 side.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);
   // datapath request
   logic              Req;
   logic              ReqRW;
   logic [ADDR_W-1:0] ReqAddr;
   logic [31:0]       ReqData;
   logic [1:0]        ReqSize;
   logic              ReqSigned;
   // datapath response
   logic              Busy;
   logic              Done;
   logic [31:0]       RdData;
   logic              Fault;
   logic [1:0]        FaultCode;
   // ram_256 handshake
   logic              Enable;
   logic              RW;
   logic [ADDR_W-1:0] Address;
   logic [31:0]       DataIn;
   logic [1:0]        DataSize;
   logic [31:0]       DataOut;
   logic              MFC;

   modport master (
      input  Req, ReqRW, ReqAddr, ReqData, ReqSize, ReqSigned,
      output Busy, Done, RdData, Fault, FaultCode,
      output Enable, RW, Address, DataIn, DataSize,
      input  DataOut, MFC
   );

   modport slave (
      output Req, ReqRW, ReqAddr, ReqData, ReqSize, ReqSigned,
      input  Busy, Done, RdData, Fault, FaultCode,
      input  Enable, RW, Address, DataIn, DataSize,
      output DataOut, MFC
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-access load/store initiator for ram_256: checks size/alignment,
// runs one Enable/MFC handshake with a timeout, formats load data.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned ADDR_W  = 8
) (
   input  logic Clk,
   input  logic Reset_n,
   mem_access_ctrl_if.master bus
);

   // Counter only needs to reach TIMEOUT-1 (last waiting cycle).
   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_ILLEG = 2'b11;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_ALIGN = 2'b01;
   localparam logic [1:0] FC_SIZE  = 2'b10;
   localparam logic [1:0] FC_TMO   = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      ACCESS  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state;
   logic              req_rw;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_data;
   logic [1:0]        req_size;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       rd_fmt_c;
   logic              misaligned_c;

   // Load data formatting: pick the low byte/half and extend per the latched signedness.
   always_comb begin
      rd_fmt_c = bus.DataOut;
      case (req_size)
         SZ_BYTE: rd_fmt_c = {{24{req_signed & bus.DataOut[7]}},  bus.DataOut[7:0]};
         SZ_HALF: rd_fmt_c = {{16{req_signed & bus.DataOut[15]}}, bus.DataOut[15:0]};
         default: rd_fmt_c = bus.DataOut;
      endcase
   end

   // Halfwords need bit 0 clear, words need bits [1:0] clear.
   always_comb begin
      misaligned_c = 1'b0;
      if (req_size == SZ_HALF && req_addr[0])
         misaligned_c = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
         misaligned_c = 1'b1;
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state          <= IDLE;
         req_rw         <= 1'b1;
         req_signed     <= 1'b0;
         req_addr       <= '0;
         req_data       <= '0;
         req_size       <= SZ_BYTE;
         cnt            <= '0;
         bus.Busy       <= 1'b0;
         bus.Done       <= 1'b0;
         bus.Fault      <= 1'b0;
         bus.FaultCode  <= FC_NONE;
         bus.RdData     <= '0;
         bus.Enable     <= 1'b0;
         bus.RW         <= 1'b1;
         bus.Address    <= '0;
         bus.DataIn     <= '0;
         bus.DataSize   <= SZ_BYTE;
      end else begin
         bus.Done  <= 1'b0;
         bus.Fault <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Req) begin
                  req_rw        <= bus.ReqRW;
                  req_signed    <= bus.ReqSigned;
                  req_addr      <= bus.ReqAddr;
                  req_data      <= bus.ReqData;
                  req_size      <= bus.ReqSize;
                  bus.FaultCode <= FC_NONE;
                  bus.Busy      <= 1'b1;
                  state         <= CHECK;
               end
            end
            CHECK: begin
               if (req_size == SZ_ILLEG) begin
                  bus.Fault     <= 1'b1;
                  bus.FaultCode <= FC_SIZE;
                  bus.Busy      <= 1'b0;
                  state         <= IDLE;
               end else if (misaligned_c) begin
                  bus.Fault     <= 1'b1;
                  bus.FaultCode <= FC_ALIGN;
                  bus.Busy      <= 1'b0;
                  state         <= IDLE;
               end else begin
                  bus.Address  <= req_addr;
                  bus.RW       <= req_rw;
                  bus.DataSize <= req_size;
                  bus.DataIn   <= req_data;
                  bus.Enable   <= 1'b1;
                  cnt          <= '0;
                  state        <= ACCESS;
               end
            end
            ACCESS: begin
               // MFC wins over a timeout landing on the same cycle.
               if (bus.MFC) begin
                  if (req_rw)
                     bus.RdData <= rd_fmt_c;
                  bus.Enable <= 1'b0;
                  bus.Done   <= 1'b1;
                  state      <= RELEASE;
               end else if (cnt == CNT_LAST) begin
                  bus.Enable    <= 1'b0;
                  bus.Fault     <= 1'b1;
                  bus.FaultCode <= FC_TMO;
                  state         <= RELEASE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               // Hold off until MFC drops so it cannot complete the next access.
               if (!bus.MFC) begin
                  bus.Busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural ram_256 responder.
module tb_mem_access_ctrl;

   localparam int unsigned TIMEOUT = 15;
   localparam int unsigned ADDR_W  = 8;

   logic Clk;
   logic Reset_n;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   mem_access_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.master)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      bit          is_fault;
      logic [1:0]  code;
      bit          chk_rd;
      logic [31:0] rd;
   } resp_t;

   typedef struct {
      logic        rw;
      logic [7:0]  addr;
      logic [1:0]  size;
      logic [31:0] data;
      bit          tmo;
   } acc_t;

   resp_t exp_q[$];
   acc_t  acc_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // ram responder controls
   int mfc_dead  = 0;
   int cur_lat   = 0;
   int mfc_hold  = 0;
   int lat_cnt   = 0;
   int hold_left = 0;

   logic [7:0] ram     [256];
   logic [7:0] ref_mem [256];
   logic [31:0] exp_rd;

   // monitor bookkeeping
   bit   en_prev  = 0;
   bit   active   = 0;
   acc_t cur;
   int   en_len   = 0;
   int   mfc_en   = 0;
   int   busy_run = 0;
   int   last_busy = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference load: assemble bytes little-endian, then extend arithmetically.
   function automatic logic [31:0] ref_load(input logic [7:0] addr, input logic [1:0] size, input logic sgn);
      int nb;
      longint unsigned v;
      nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      v = 0;
      for (int i = 0; i < nb; i++)
         v = v + (longint'(ref_mem[(int'(addr) + i) % 256]) << (8 * i));
      if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
         v = v + (longint'(1) << 32) - (longint'(1) << (8 * nb));
      return 32'(v);
   endfunction

   task automatic ref_store(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] size);
      int nb;
      nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++)
         ref_mem[(int'(addr) + i) % 256] = 8'((data >> (8 * i)) & 32'hFF);
   endtask

   // Behavioural ram_256: MFC after cur_lat cycles, held mfc_hold extra cycles after Enable drops.
   always @(posedge Clk) begin
      if (bus.Enable && mfc_dead == 0) begin
         if (!bus.MFC) begin
            if (lat_cnt >= cur_lat) begin
               if (bus.RW) begin
                  bus.DataOut <= {ram[8'(bus.Address + 8'd3)], ram[8'(bus.Address + 8'd2)],
                                  ram[8'(bus.Address + 8'd1)], ram[bus.Address]};
               end else begin
                  ram[bus.Address] <= bus.DataIn[7:0];
                  if (bus.DataSize != 2'b00)
                     ram[8'(bus.Address + 8'd1)] <= bus.DataIn[15:8];
                  if (bus.DataSize == 2'b10) begin
                     ram[8'(bus.Address + 8'd2)] <= bus.DataIn[23:16];
                     ram[8'(bus.Address + 8'd3)] <= bus.DataIn[31:24];
                  end
               end
               bus.MFC  <= 1'b1;
               hold_left = mfc_hold;
               lat_cnt   = 0;
            end else begin
               lat_cnt++;
            end
         end
      end else begin
         lat_cnt = 0;
         if (bus.MFC) begin
            if (hold_left > 0) hold_left--;
            else bus.MFC <= 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on Done/Fault and polices the RAM handshake.
   always @(negedge Clk) begin
      if (!Reset_n) begin
         en_prev  = 0;
         active   = 0;
         busy_run = 0;
      end else begin
         if (bus.Done && bus.Fault)
            chk("done_fault_overlap", 32'(bus.Done & bus.Fault), 32'd0);
         if (bus.Done) done_cnt++;
         if (bus.Done || bus.Fault) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_response", 32'({bus.Done, bus.Fault}), 32'd0);
            end else begin
               resp_t e;
               e = exp_q.pop_front();
               chk("resp_is_fault", 32'(bus.Fault), 32'(e.is_fault));
               if (e.is_fault)
                  chk("fault_code", 32'(bus.FaultCode), 32'(e.code));
               else if (e.chk_rd)
                  chk("rd_data", bus.RdData, e.rd);
            end
         end
         if (bus.Enable) begin
            if (!en_prev) begin
               if (acc_q.size() == 0) begin
                  chk("enable_without_access", 32'(bus.Enable), 32'd0);
                  active = 0;
               end else begin
                  cur    = acc_q.pop_front();
                  active = 1;
                  en_len = 0;
                  mfc_en = 0;
               end
            end
            if (active) begin
               chk("ram_addr", 32'(bus.Address), 32'(cur.addr));
               chk("ram_rw", 32'(bus.RW), 32'(cur.rw));
               chk("ram_size", 32'(bus.DataSize), 32'(cur.size));
               chk("ram_datain", bus.DataIn, cur.data);
            end
            en_len++;
            if (bus.MFC) mfc_en++;
         end else if (en_prev && active) begin
            if (cur.tmo) begin
               chk("tmo_enable_len", 32'(en_len), 32'(TIMEOUT));
               chk("tmo_mfc_seen", 32'(mfc_en), 32'd0);
            end else begin
               chk("enable_mfc_cycles", 32'(mfc_en), 32'd1);
            end
            active = 0;
         end
         en_prev = bus.Enable;
         if (bus.MFC && !bus.Busy)
            chk("busy_during_mfc", 32'(bus.Busy), 32'd1);
         if (bus.Busy) busy_run++;
         else if (busy_run > 0) begin
            last_busy = busy_run;
            busy_run  = 0;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.Busy !== 1'b0 && n < 100) begin
         @(negedge Clk); #1;
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'(bus.Busy), 32'd0);
   endtask

   task automatic issue(input logic rw, input logic [7:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input logic sgn);
      resp_t e;
      acc_t  a;
      int    n;
      wait_idle();
      e.is_fault = 0; e.code = 2'b00; e.chk_rd = 0; e.rd = '0;
      if (size == 2'b11) begin
         e.is_fault = 1; e.code = 2'b10;
      end else if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) begin
         e.is_fault = 1; e.code = 2'b01;
      end else begin
         a.rw = rw; a.addr = addr; a.size = size; a.data = data; a.tmo = (mfc_dead != 0);
         acc_q.push_back(a);
         if (mfc_dead != 0) begin
            e.is_fault = 1; e.code = 2'b11;
         end else begin
            if (rw) exp_rd = ref_load(addr, size, sgn);
            else    ref_store(addr, data, size);
            e.chk_rd = 1;
            e.rd     = exp_rd;
         end
      end
      exp_q.push_back(e);
      @(negedge Clk);
      bus.Req = 1'b1; bus.ReqRW = rw; bus.ReqAddr = addr; bus.ReqData = data;
      bus.ReqSize = size; bus.ReqSigned = sgn;
      @(negedge Clk);
      bus.Req = 1'b0;
      bus.ReqData = $urandom;
      n = 0;
      while ((exp_q.size() != 0 || bus.Busy !== 1'b0) && n < 200) begin
         @(negedge Clk); #1;
         n++;
      end
      if (n >= 200) begin
         chk("response_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         acc_q.delete();
      end
   endtask

   task automatic check_reset();
      chk("rst_enable", 32'(bus.Enable), 32'd0);
      chk("rst_rw", 32'(bus.RW), 32'd1);
      chk("rst_address", 32'(bus.Address), 32'd0);
      chk("rst_datain", bus.DataIn, 32'd0);
      chk("rst_datasize", 32'(bus.DataSize), 32'd0);
      chk("rst_busy", 32'(bus.Busy), 32'd0);
      chk("rst_done", 32'(bus.Done), 32'd0);
      chk("rst_fault", 32'(bus.Fault), 32'd0);
      chk("rst_faultcode", 32'(bus.FaultCode), 32'd0);
      chk("rst_rddata", bus.RdData, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      bus.Req = 1'b0; bus.ReqRW = 1'b1; bus.ReqAddr = '0; bus.ReqData = '0;
      bus.ReqSize = 2'b00; bus.ReqSigned = 1'b0;
      bus.MFC = 1'b0; bus.DataOut = '0;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      exp_rd  = '0;
      Reset_n = 1'b1;
      #1 Reset_n = 1'b0;
      #2 check_reset();
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk); #1;
      check_reset();

      // store byte, unsigned byte load
      cur_lat = 1;
      issue(1'b0, 8'h00, 32'hFFFFFF0B, 2'b00, 1'b0);
      issue(1'b1, 8'h00, 32'h0, 2'b00, 1'b0);
      chk("t1_load_byte", bus.RdData, 32'h0000000B);

      // store half, signed and unsigned half loads
      cur_lat = 0;
      issue(1'b0, 8'hF0, 32'hABCDEF1A, 2'b01, 1'b0);
      issue(1'b1, 8'hF0, 32'h0, 2'b01, 1'b1);
      chk("t2_load_half_s", bus.RdData, 32'hFFFFEF1A);
      issue(1'b1, 8'hF0, 32'h0, 2'b01, 1'b0);
      chk("t2_load_half_u", bus.RdData, 32'h0000EF1A);

      // store and load word at top of memory
      cur_lat = 3;
      issue(1'b0, 8'hFC, 32'hABCDEF1C, 2'b10, 1'b0);
      issue(1'b1, 8'hFC, 32'h0, 2'b10, 1'b0);
      chk("t3_load_word", bus.RdData, 32'hABCDEF1C);

      // check-stage faults never reach the RAM
      issue(1'b1, 8'hF1, 32'h0, 2'b01, 1'b0);
      chk("t4_align_code", 32'(bus.FaultCode), 32'd1);
      chk("t4_align_busy_short", 32'(last_busy <= 2 && last_busy >= 1), 32'd1);
      issue(1'b0, 8'h00, 32'h12345678, 2'b11, 1'b0);
      chk("t4_size_code", 32'(bus.FaultCode), 32'd2);
      chk("t4_size_busy_short", 32'(last_busy <= 2 && last_busy >= 1), 32'd1);
      chk("t4_rd_kept", bus.RdData, 32'hABCDEF1C);

      // timeout with a silent RAM
      mfc_dead = 1;
      d0 = done_cnt;
      issue(1'b1, 8'h10, 32'h0, 2'b10, 1'b0);
      chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
      chk("t5_code_held", 32'(bus.FaultCode), 32'd3);
      mfc_dead = 0;

      // stale MFC held after completion
      mfc_hold = 3;
      d0 = done_cnt;
      issue(1'b1, 8'hF0, 32'h0, 2'b00, 1'b1);
      chk("t6_one_done", 32'(done_cnt - d0), 32'd1);
      chk("t6_held_busy", 32'(last_busy >= 6), 32'd1);
      mfc_hold = 0;

      // reset in the middle of an access
      mfc_dead = 1;
      begin
         acc_t a;
         a.rw = 1'b1; a.addr = 8'h20; a.size = 2'b10; a.data = 32'hCAFEF00D; a.tmo = 1;
         acc_q.push_back(a);
      end
      @(negedge Clk);
      bus.Req = 1'b1; bus.ReqRW = 1'b1; bus.ReqAddr = 8'h20; bus.ReqData = 32'hCAFEF00D;
      bus.ReqSize = 2'b10; bus.ReqSigned = 1'b0;
      @(negedge Clk);
      bus.Req = 1'b0;
      repeat (4) @(posedge Clk);
      #2;
      chk("t6_enable_before_rst", 32'(bus.Enable), 32'd1);
      Reset_n = 1'b0;
      #1 check_reset();
      exp_q.delete();
      acc_q.delete();
      exp_rd = '0;
      mfc_dead = 0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (TIMEOUT + 5) @(negedge Clk);
      #1 chk("t6_quiet_after_rst", 32'(bus.Busy), 32'd0);

      // randomized traffic
      for (int t = 0; t < 80; t++) begin
         logic       rw;
         logic [1:0] sz;
         logic [7:0] ad;
         rw = 1'($urandom);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         ad = 8'($urandom);
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'b01) ad[0] = 1'b0;
            if (sz == 2'b10) ad[1:0] = 2'b00;
         end
         cur_lat  = $urandom_range(0, 3);
         mfc_hold = $urandom_range(0, 2);
         mfc_dead = ($urandom_range(0, 14) == 0) ? 1 : 0;
         issue(rw, ad, $urandom, sz, 1'($urandom));
      end
      mfc_dead = 0;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
